// File: rtl/serial_deaccumulator_if.sv
// Bus bundle for serial_deaccumulator: preset/load controls, the subtrahend,
// and the registered running value with its done/busy/borrow status.
// master drives the controls and observes the results; slave is the block.
interface serial_deaccumulator_if #(
  parameter int N = 8
);
  logic         preset_en;
  logic [N-1:0] preset_data;
  logic         load_input;
  logic [N-1:0] input_data;
  logic [N-1:0] diff_out;
  logic         done;
  logic         busy;
  logic         borrow_out;

  modport master (
    output preset_en, preset_data, load_input, input_data,
    input  diff_out, done, busy, borrow_out
  );

  modport slave (
    input  preset_en, preset_data, load_input, input_data,
    output diff_out, done, busy, borrow_out
  );
endinterface

// File: rtl/serial_deaccumulator.sv
// serial_deaccumulator: bit-serial running subtractor.
// The running value (diff_out) is the minuend. Each accepted load subtracts
// input_data one bit per cycle, LSB first, then commits the result in a
// final cycle with a one-cycle done pulse.
// Optional feature: define SERIAL_DEACC_SATURATE_EN to clamp an underflowing
// result to zero instead of wrapping modulo 2^N (borrow_out is 1 either way).
module serial_deaccumulator #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_deaccumulator_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SUB, COMMIT} state_t;

  state_t        state;
  logic [N-1:0]  a_shift;     // remaining minuend bits, current bit at [0]
  logic [N-1:0]  b_shift;     // remaining subtrahend bits, current bit at [0]
  logic [N-1:0]  result;      // difference bits shifted in from the top
  logic [IW-1:0] bit_idx;
  logic          borrow;      // borrow into the current bit
  logic [N-1:0]  diff_out;
  logic          done;
  logic          borrow_out;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic bout_bit;

  // One-bit full subtractor on the current operand bits
  assign a_bit    = a_shift[0];
  assign b_bit    = b_shift[0];
  assign d_bit    = a_bit ^ b_bit ^ borrow;
  assign bout_bit = (~a_bit & b_bit) | (~a_bit & borrow) | (b_bit & borrow);

  assign bus.diff_out   = diff_out;
  assign bus.done       = done;
  assign bus.borrow_out = borrow_out;
  assign bus.busy       = (state != IDLE);

  // Control FSM plus operand/result datapath; preset overrides any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_shift    <= '0;
      b_shift    <= '0;
      result     <= '0;
      bit_idx    <= '0;
      borrow     <= 1'b0;
      diff_out   <= '0;
      done       <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.preset_en) begin
        diff_out   <= bus.preset_data;
        borrow_out <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.load_input) begin
              a_shift <= diff_out;
              b_shift <= bus.input_data;
              result  <= '0;
              bit_idx <= '0;
              borrow  <= 1'b0;
              state   <= SUB;
            end
          end
          SUB: begin
            a_shift <= a_shift >> 1;
            b_shift <= b_shift >> 1;
            result  <= {d_bit, result[N-1:1]};
            borrow  <= bout_bit;
            bit_idx <= bit_idx + IW'(1);
            if (bit_idx == LAST_IDX) begin
              state <= COMMIT;
            end
          end
          COMMIT: begin
`ifdef SERIAL_DEACC_SATURATE_EN
            diff_out <= borrow ? '0 : result;
`else
            diff_out <= result;
`endif
            borrow_out <= borrow;
            done       <= 1'b1;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/serial_deaccumulator.md
SERIAL_DEACCUMULATOR -- requirements
Module: serial_deaccumulator

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and result width in bits; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port preset_en, input, 1 bit: loads preset_data into the running value.
REQ-005 The block SHALL have port preset_data, input, N bits: the value loaded by preset_en.
REQ-006 The block SHALL have port load_input, input, 1 bit: request to subtract input_data from the running value.
REQ-007 The block SHALL have port input_data, input, N bits: the subtrahend, sampled only on an accepted load_input.
REQ-008 The block SHALL have port diff_out, output, N bits, registered: the running value.
REQ-009 The block SHALL have port done, output, 1 bit, registered: one-cycle pulse when diff_out is updated by a subtraction.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port borrow_out, output, 1 bit, registered: final borrow of the last committed subtraction (1 = underflow).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SUB and COMMIT.
REQ-013 Priority each cycle SHALL be: reset > preset_en > load_input > FSM progress.
REQ-014 preset_en in any state SHALL load diff_out with preset_data, clear borrow_out, abort any operation in progress, go to IDLE, and produce no done pulse.
REQ-015 load_input SHALL be accepted only in IDLE; in SUB or COMMIT it SHALL be ignored without affecting state or outputs.
REQ-016 On acceptance, the block SHALL latch minuend = diff_out and subtrahend = input_data, clear the bit index and borrow-in, and move to SUB.
REQ-017 SUB SHALL process one bit per cycle, LSB first, over N cycles, using d = a^b^bin and bout = (~a&b)|(~a&bin)|(b&bin), with a = minuend bit, b = subtrahend bit, bin = registered borrow.
REQ-018 After bit N-1 is processed, the FSM SHALL enter COMMIT and hold the final borrow.
REQ-019 In COMMIT, the block SHALL write diff_out and borrow_out, drive done high for exactly that one cycle, and return to IDLE.
REQ-020 Latency SHALL be fixed: for a load accepted at edge k, diff_out and done SHALL update at edge k+N+1.
REQ-021 Outside COMMIT, done SHALL be 0.
REQ-022 Outside COMMIT and preset, diff_out and borrow_out SHALL hold their values.
REQ-023 A load_input asserted in the cycle done is high SHALL be accepted (FSM already in IDLE), allowing back-to-back operations every N+1 cycles.
REQ-024 Arithmetic SHALL be modulo 2^N, except as modified by REQ-029.
REQ-025 input_data SHALL be sampled only on the accepting edge; later changes to it SHALL not affect the result.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE and clear diff_out, done, borrow_out, the operand registers, the bit index and the borrow register.
REQ-027 Reset asserted mid-SUB or mid-COMMIT SHALL discard the operation and produce no done pulse.
REQ-028 After reset deasserts, busy SHALL be 0 and the block SHALL accept load_input on the first clock edge.

Configuration
REQ-029 When macro SERIAL_DEACC_SATURATE_EN is defined, a COMMIT with final borrow = 1 SHALL write diff_out = 0 and borrow_out = 1; when undefined, COMMIT SHALL write the wrapped modulo 2^N difference with borrow_out = 1.

Verification
REQ-030 Reset, preset 100, load 30 -> 9 cycles later diff_out = 70, done high for 1 cycle, borrow_out = 0, busy low.
REQ-031 diff_out = 70, load 70 -> diff_out = 0, borrow_out = 0; then load 0 -> diff_out = 0, done pulses.
REQ-032 Preset 5, load 10 -> without macro diff_out = 251, borrow_out = 1; with SERIAL_DEACC_SATURATE_EN diff_out = 0, borrow_out = 1.
REQ-033 Preset 200, load 50, load 90 pulsed in SUB cycle 3 -> result 150 only; busy high for 9 cycles; second load ignored.
REQ-034 Preset 200, load 50, preset 7 in SUB cycle 4 -> diff_out = 7, no done pulse, busy low next cycle.
REQ-035 Load 1 from 255 with reset asserted mid-SUB -> all outputs 0, IDLE; then preset 255, load 1 with load 1 re-asserted on the done cycle -> 254, then 253 nine cycles later.
